// File: rtl/word_pkg.sv
// Shared letter codes, word packing and the constant word ROM for the typing game.
package word_pkg;

    localparam int LETTER_W = 5;
    localparam int WORD_W   = 20;
    localparam int ROM_DEPTH = 32;

    localparam logic [LETTER_W-1:0]
        L_A = 5'd1,  L_B = 5'd2,  L_C = 5'd3,  L_D = 5'd4,  L_E = 5'd5,  L_F = 5'd6,
        L_G = 5'd7,  L_H = 5'd8,  L_I = 5'd9,  L_J = 5'd10, L_K = 5'd11, L_L = 5'd12,
        L_M = 5'd13, L_N = 5'd14, L_O = 5'd15, L_P = 5'd16, L_Q = 5'd17, L_R = 5'd18,
        L_S = 5'd19, L_T = 5'd20, L_U = 5'd21, L_V = 5'd22, L_W = 5'd23, L_X = 5'd24,
        L_Y = 5'd25, L_Z = 5'd26;
    localparam logic [LETTER_W-1:0] KEY_START = 5'd31;

    // Letter 1 is typed first and sits in the low bits.
    function automatic logic [WORD_W-1:0] pack(input logic [LETTER_W-1:0] l1, l2, l3, l4);
        return {l4, l3, l2, l1};
    endfunction

    localparam logic [WORD_W-1:0] WORD_ROM [ROM_DEPTH] = '{
        pack(L_G, L_A, L_M, L_E), pack(L_W, L_O, L_R, L_D),
        pack(L_T, L_Y, L_P, L_E), pack(L_F, L_A, L_S, L_T),
        pack(L_K, L_E, L_Y, L_S), pack(L_L, L_O, L_O, L_P),
        pack(L_B, L_Y, L_T, L_E), pack(L_C, L_O, L_D, L_E),
        pack(L_W, L_A, L_V, L_E), pack(L_J, L_U, L_M, L_P),
        pack(L_Q, L_U, L_I, L_Z), pack(L_Z, L_O, L_N, L_E),
        pack(L_F, L_R, L_O, L_G), pack(L_H, L_E, L_L, L_P),
        pack(L_M, L_I, L_N, L_T), pack(L_N, L_A, L_V, L_Y),
        pack(L_E, L_C, L_H, L_O), pack(L_P, L_L, L_A, L_Y),
        pack(L_S, L_H, L_I, L_P), pack(L_R, L_O, L_C, L_K),
        pack(L_B, L_L, L_U, L_E), pack(L_D, L_U, L_S, L_K),
        pack(L_I, L_R, L_O, L_N), pack(L_L, L_A, L_M, L_P),
        pack(L_V, L_O, L_L, L_T), pack(L_X, L_R, L_A, L_Y),
        pack(L_Y, L_A, L_R, L_N), pack(L_T, L_R, L_E, L_E),
        pack(L_S, L_N, L_O, L_W), pack(L_H, L_A, L_W, L_K),
        pack(L_O, L_P, L_A, L_L), pack(L_K, L_N, L_O, L_T)
    };

    // Index counts above ROM_DEPTH wrap onto the stored words.
    function automatic logic [WORD_W-1:0] rom_word(input logic [4:0] idx);
        return WORD_ROM[idx];
    endfunction

endpackage

// File: rtl/word_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module word_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= SEED;
        end else begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/word_delivery.sv
// Current / look-ahead word pair, advanced once per rising edge of wordComplete.
module word_delivery
    import word_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         WORD_COUNT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wordComplete,
    output logic [WORD_W-1:0] currentWord,
    output logic [WORD_W-1:0] nextWord
);

    localparam int IW = $clog2(WORD_COUNT);

    logic [7:0]    lfsr;
    logic          s1, s2, s3;
    logic          advance;
    logic [IW-1:0] cur_idx, next_idx;
    logic [IW-1:0] cand, cand_adj;

    word_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .value(lfsr)
    );

    if (IW < 8) begin : g_lfsr_spare
        logic unused_lfsr;
        assign unused_lfsr = ^lfsr[7:IW];
    end

    assign advance  = s2 & ~s3;
    assign cand     = lfsr[IW-1:0];
    // Bumping a collision keeps the two displayed words different.
    assign cand_adj = (cand == next_idx) ? cand + IW'(1) : cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cur_idx  <= '0;
            next_idx <= IW'(1);
        end else begin
            s1 <= wordComplete;
            s2 <= s1;
            s3 <= s2;
            if (advance) begin
                cur_idx  <= next_idx;
                next_idx <= cand_adj;
            end
        end
    end

    assign currentWord = rom_word(5'(cur_idx));
    assign nextWord    = rom_word(5'(next_idx));

endmodule

// File: tb/tb_word_delivery.sv
// Scoreboard bench for word_delivery: reference LFSR/index model and an independent word list.
module tb_word_delivery;

    logic        clk;
    logic        reset;
    logic        wordComplete;
    logic [19:0] currentWord, nextWord;

    word_delivery dut (
        .clk         (clk),
        .reset       (reset),
        .wordComplete(wordComplete),
        .currentWord (currentWord),
        .nextWord    (nextWord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] cur;
        logic [19:0] nxt;
    } exp_t;

    typedef struct {
        int hi1;
        int lo1;
        int hi2;
        int lo2;
        int exp_adv;
    } pat_t;

    string words [32] = '{
        "GAME", "WORD", "TYPE", "FAST", "KEYS", "LOOP", "BYTE", "CODE",
        "WAVE", "JUMP", "QUIZ", "ZONE", "FROG", "HELP", "MINT", "NAVY",
        "ECHO", "PLAY", "SHIP", "ROCK", "BLUE", "DUSK", "IRON", "LAMP",
        "VOLT", "XRAY", "YARN", "TREE", "SNOW", "HAWK", "OPAL", "KNOT"
    };

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_adv    = 0;
    logic [7:0]  m_lfsr;
    logic [4:0]  m_cur, m_next;
    logic [19:0] last_cur, last_next;

    function automatic logic [19:0] bw(input logic [4:0] idx);
        logic [19:0] w;
        string s;
        s = words[idx];
        w = '0;
        for (int i = 0; i < 4; i++) w[5*i +: 5] = 5'(s[i] - 8'd64);
        return w;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic bit letters_ok(input logic [19:0] w);
        for (int i = 0; i < 4; i++)
            if (w[5*i +: 5] < 5'd1 || w[5*i +: 5] > 5'd26) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input bit cond, input logic [31:0] act);
        n_checks++;
        if (!cond) begin
            n_fails++;
            $display("FAIL %s: observed value %h", name, act);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= step(m_lfsr);
    end

    always @(negedge clk) begin
        if (!reset) begin
            last_cur  = currentWord;
            last_next = nextWord;
        end else if (currentWord !== last_cur || nextWord !== last_next) begin
            if (sb.size() == 0) begin
                chk_true("unexpected_change", 1'b0, 32'(currentWord));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("current_word", currentWord, e.cur);
                chk("next_word", nextWord, e.nxt);
                chk("shift_chain", currentWord, last_next);
                chk_true("words_differ", currentWord != nextWord, 32'(nextWord));
                chk_true("letters_valid", letters_ok(currentWord) && letters_ok(nextWord), 32'(nextWord));
            end
            n_adv++;
            last_cur  = currentWord;
            last_next = nextWord;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Call on the cycle wordComplete rises: the advance lands two LFSR steps later.
    task automatic push_adv();
        logic [7:0] l;
        logic [4:0] cand;
        exp_t e;
        l    = step(step(m_lfsr));
        cand = l[4:0];
        if (cand == m_next) cand = cand + 5'd1;
        m_cur  = m_next;
        m_next = cand;
        e.cur  = bw(m_cur);
        e.nxt  = bw(m_next);
        sb.push_back(e);
    endtask

    task automatic pulse(input int hi, input int lo);
        wordComplete = 1'b1;
        push_adv();
        tick(hi);
        wordComplete = 1'b0;
        tick(lo);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        chk_true("drain_timeout", sb.size() == 0, 32'(sb.size()));
        sb.delete();
    endtask

    task automatic model_reset();
        sb.delete();
        m_cur  = 5'd0;
        m_next = 5'd1;
    endtask

    pat_t pats [5];
    logic [19:0] first_next;
    int adv0;

    initial begin
        pats[0] = '{hi1: 10, lo1: 3, hi2: 0, lo2: 0, exp_adv: 1};
        pats[1] = '{hi1: 1,  lo1: 1, hi2: 1, lo2: 3, exp_adv: 2};
        pats[2] = '{hi1: 2,  lo1: 1, hi2: 2, lo2: 4, exp_adv: 2};
        pats[3] = '{hi1: 1,  lo1: 4, hi2: 0, lo2: 0, exp_adv: 1};
        pats[4] = '{hi1: 5,  lo1: 2, hi2: 1, lo2: 3, exp_adv: 2};

        reset = 1'b0;
        wordComplete = 1'b0;
        model_reset();
        tick(3);
        chk("reset_current", currentWord, 20'h2B427);
        chk("reset_next", nextWord, 20'h249F7);
        reset = 1'b1;
        tick(50);
        chk("idle_current", currentWord, 20'h2B427);
        chk("idle_next", nextWord, 20'h249F7);

        // Single advance held high: latency and no re-trigger while held.
        wordComplete = 1'b1;
        push_adv();
        tick(2);
        chk("latency_early", currentWord, 20'h2B427);
        tick(1);
        chk("latency_current", currentWord, 20'h249F7);
        chk_true("first_next_differs", nextWord != 20'h249F7, 32'(nextWord));
        tick(9);
        wordComplete = 1'b0;
        tick(2);
        drain();

        for (int p = 0; p < 5; p++) begin
            adv0 = n_adv;
            pulse(pats[p].hi1, pats[p].lo1);
            if (pats[p].hi2 > 0) pulse(pats[p].hi2, pats[p].lo2);
            drain();
            tick(3);
            chk_true("pattern_advances", (n_adv - adv0) == pats[p].exp_adv, 32'(n_adv - adv0));
        end

        // Game-start refill: 1,0,1 gives two advances.
        adv0 = n_adv;
        pulse(1, 1);
        first_next = bw(m_next);
        pulse(1, 4);
        drain();
        chk_true("start_two_advances", (n_adv - adv0) == 2, 32'(n_adv - adv0));
        chk("start_current", currentWord, first_next);

        for (int k = 0; k < 200; k++) pulse(1, 4);
        drain();

        // Reset one cycle after a rise discards the in-flight edge.
        wordComplete = 1'b1;
        tick(1);
        reset = 1'b0;
        wordComplete = 1'b0;
        model_reset();
        #1;
        chk("midreset_current", currentWord, 20'h2B427);
        chk("midreset_next", nextWord, 20'h249F7);
        tick(2);
        reset = 1'b1;
        adv0 = n_adv;
        tick(10);
        chk_true("midreset_no_advance", n_adv == adv0, 32'(n_adv - adv0));
        chk("midreset_hold", currentWord, 20'h2B427);

        // Release with wordComplete already high yields exactly one advance.
        reset = 1'b0;
        wordComplete = 1'b1;
        model_reset();
        tick(2);
        reset = 1'b1;
        adv0 = n_adv;
        push_adv();
        tick(2);
        chk("release_early", currentWord, 20'h2B427);
        tick(1);
        chk_true("release_advance_seen", sb.size() == 0, 32'(sb.size()));
        chk("release_current", currentWord, 20'h249F7);
        tick(6);
        wordComplete = 1'b0;
        tick(5);
        drain();
        chk_true("release_one_advance", (n_adv - adv0) == 1, 32'(n_adv - adv0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
